// File: rtl/scale_mux_pkg.sv
// Shared types and constants for scale_mux_rr: output-stage state, default sizes
// and the round-robin wrap helper.
package scale_mux_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   localparam int DEF_WIDTH    = 5;
   localparam int DEF_CHANNELS = 4;

   function automatic int wrap_inc(input int i, input int n);
      return (i + 1) % n;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 with wrap-around and grants the first
// requester. Outputs a one-hot grant, its binary index and an any-grant flag.
module rr_arbiter
   import scale_mux_pkg::*;
#(
   parameter  int CHANNELS = DEF_CHANNELS,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   input  logic                enable,
   output logic [CHANNELS-1:0] grant,
   output logic [SEL_W-1:0]    grant_idx,
   output logic                any
);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = int'(ptr);
      for (int k = 0; k < CHANNELS; k++) begin
         idx = wrap_inc(idx, CHANNELS);
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = SEL_W'(idx);
         end
      end
      any = found && enable;
      if (any) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/scale_mux_rr.sv
// N-channel registered mux with valid/ready handshakes and round-robin selection.
// Defining SCALE_MUX_SEL_EN adds sel_mode/sel for an explicit-channel override.
module scale_mux_rr
   import scale_mux_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int CHANNELS = DEF_CHANNELS,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan
`ifdef SCALE_MUX_SEL_EN
   ,
   input  logic                      sel_mode,
   input  logic [SEL_W-1:0]          sel
`endif
);

   // Handshake: a word moves on channel g when in_valid[g] && in_ready[g];
   // the consumer takes out_data when out_valid && out_ready.
   out_state_t          state;
   logic [SEL_W-1:0]    ptr;
   logic [CHANNELS-1:0] req;
   logic                accept;
   logic                enable;
   logic [SEL_W-1:0]    grant_idx;
   logic                any;

`ifdef SCALE_MUX_SEL_EN
   // Explicit mode masks every request except channel sel; out-of-range sel masks all.
   always_comb begin
      req = in_valid;
      if (sel_mode) begin
         req = '0;
         for (int i = 0; i < CHANNELS; i++)
            if (sel == SEL_W'(i)) req[i] = in_valid[i];
      end
   end
`else
   assign req = in_valid;
`endif

   assign accept    = (state == EMPTY) || out_ready;
   assign enable    = accept && !rst;
   assign out_valid = (state == FULL);

   rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
      .req       (req),
      .ptr       (ptr),
      .enable    (enable),
      .grant     (in_ready),
      .grant_idx (grant_idx),
      .any       (any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         out_data <= '0;
         out_chan <= '0;
         ptr      <= SEL_W'(CHANNELS - 1);
      end else if (any) begin
         state    <= FULL;
         out_data <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
         out_chan <= grant_idx;
         ptr      <= grant_idx;
      end else if (state == FULL && out_ready) begin
         state <= EMPTY;
      end
   end

endmodule

// File: doc/scale_mux_rr.md
# scale_mux_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes and round-robin channel selection. It is the generalisation of the 2:1 `scale_mux`. Use it wherever several producers in the RISC-V datapath share one consumer, for example writeback sources or bus requesters. One output register stage decouples the channel selection logic from the consumer.

## Interface
- `WIDTH`, default 5: data width per channel, ≥1.
- `CHANNELS`, default 4: number of input channels, ≥2; need not be a power of two.
- `SEL_W`, derived localparam: `$clog2(CHANNELS)`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in CHANNELS: per-channel request.
- `in_ready` out CHANNELS: per-channel accept. At most one bit is high in any cycle.
- `in_data` in CHANNELS*WIDTH: flattened inputs. Channel i occupies `[i*WIDTH +: WIDTH]`.
- `out_valid` out 1: the output register holds a word.
- `out_ready` in 1: the consumer accepts the word.
- `out_data` out WIDTH: the registered word.
- `out_chan` out SEL_W: index of the channel that supplied `out_data`.
- `sel_mode` in 1: select mode (only with `SCALE_MUX_SEL_EN`). 0 = round-robin, 1 = explicit.
- `sel` in SEL_W: explicit channel (only with `SCALE_MUX_SEL_EN`).

## Operation
- Output stage has two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `accept = !out_valid || out_ready`.
- Grant rule:
  - Round-robin search starts at `ptr+1` and wraps from CHANNELS-1 to 0.
  - The first channel found with `in_valid`=1 wins.
  - `in_ready[g] = accept && (grant == g)`. All other `in_ready` bits are 0.
- Transfer on channel g (`in_valid[g] && in_ready[g]`):
  - `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
  - `ptr <= g`.
- Drain without a new transfer (`out_valid && out_ready`, no grant): `out_valid <= 0`. `out_data` and `out_chan` hold their last values.
- No `in_valid` bit set: no grant, `ptr` unchanged.
- FULL with `out_ready`=0: all `in_ready` are 0, and `out_data`/`out_chan` stay stable.
- Simultaneous drain and new transfer: the register reloads and stays FULL. Throughput is one word per cycle.
- `in_ready` is combinational from `in_valid`, `out_valid` and `out_ready`. `out_*` are registered only.
- Producers must not drop `in_valid` or change `in_data` before their handshake completes. The arbiter may re-grant each cycle.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_chan`=0.
  - `ptr`=CHANNELS-1, so channel 0 has first priority after reset.
  - `in_ready` is 0 while `rst` is asserted.
- Latency: a word accepted at edge n is visible on `out_data` after edge n, i.e. 1 cycle.
- Reset asserted mid-operation: the held word is discarded, `out_valid` drops immediately, and `ptr` returns to CHANNELS-1.
- Fairness: with all channels requesting continuously and `out_ready`=1, each channel is granted exactly once every CHANNELS cycles.

## Configuration
- `SCALE_MUX_SEL_EN` defined:
  - The `sel_mode` and `sel` ports exist.
  - With `sel_mode`=1, only channel `sel` can be granted, and only when its `in_valid` is set.
  - `sel` ≥ CHANNELS grants nothing.
  - `ptr` still updates on every transfer.
- `SCALE_MUX_SEL_EN` undefined: the ports are absent and the block is always round-robin.

## Structure
- Package `scale_mux_pkg` contains:
  - the output state enum (EMPTY, FULL);
  - the default `WIDTH` and `CHANNELS` constants;
  - a helper that computes the wrap-around index `(i+1) % CHANNELS`.
- Sub-module `rr_arbiter`, parameterised on CHANNELS:
  - inputs: `req`, `ptr`, `enable`;
  - outputs: one-hot `grant`, binary `grant_idx`, `any`.
- The top level instantiates `rr_arbiter` and contains the output register, the pointer and the optional select override.

## Test plan
All scenarios use WIDTH=5, CHANNELS=4.
1. Reset, then `in_valid`=4'b1111 with data 1,2,3,4 and `out_ready`=1 → grants follow channels 0,1,2,3,0.
   - `out_data` sequence 00001, 00010, 00011, 00100, one cycle after each grant.
   - `out_chan` sequence 0,1,2,3.
2. Backpressure: `out_ready`=0 while FULL with 11111 → `in_ready`=0000 and `out_data` stays at 11111 for 5 cycles. Raising `out_ready` drains it and loads the next channel in the same cycle.
3. Sparse requests: only channel 2 valid with 10101, then only channel 1 valid → channel 2 is granted, `ptr`=2, then channel 1 is granted. No idle grants occur and `out_valid` drops when no request is present.
4. Reset while FULL → `out_valid` is 0 immediately. With channels 3 and 0 valid after reset, channel 0 wins first.
5. Only with `SCALE_MUX_SEL_EN`: `sel_mode`=1 and `sel`=3 with all valid → only channel 3 is granted.
   - With `sel`=3 and `in_valid[3]`=0 → no grant.
6. Only with `SCALE_MUX_SEL_EN`: switching `sel_mode` from 1 back to 0 after channel 3 was granted → the next round-robin grant is channel 0.
